// File: rtl/plab5_mcore_test_mem_multi_domain.sv
// Partitioned test memory with per-domain access control,
// one-entry response stage and a word-serial partition clear engine.
module plab5_mcore_test_mem_multi_domain #(
  parameter int p_num_parts    = 4,
  parameter int p_part_nbytes  = 256,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  localparam int c_dn = $clog2(p_num_parts),
  localparam int c_nb = p_data_nbits / 8,
  localparam int c_ln = $clog2(c_nb)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memreq_val,
  output logic                      memreq_rdy,
  input  logic [2:0]                memreq_type,
  input  logic [p_opaque_nbits-1:0] memreq_opaque,
  input  logic [p_addr_nbits-1:0]   memreq_addr,
  input  logic [c_ln-1:0]           memreq_len,
  input  logic [p_data_nbits-1:0]   memreq_data,
  input  logic [c_dn-1:0]           memreq_domain,
  output logic                      memresp_val,
  input  logic                      memresp_rdy,
  output logic [2:0]                memresp_type,
  output logic [p_opaque_nbits-1:0] memresp_opaque,
  output logic [c_ln-1:0]           memresp_len,
  output logic [p_data_nbits-1:0]   memresp_data,
  output logic [c_dn-1:0]           memresp_domain,
  output logic                      memresp_err,
  input  logic                      mem_clear,
  input  logic [c_dn-1:0]           mem_clear_part,
  output logic                      clear_busy
);

  localparam int c_pb = $clog2(p_part_nbytes);
  localparam int c_wn = c_pb - c_ln;
  localparam int c_iw = c_dn + c_wn;
  localparam int c_w  = p_part_nbytes / c_nb;
  localparam int c_nw = p_num_parts * c_w;

  localparam logic [2:0] T_RD  = 3'd0;
  localparam logic [2:0] T_WR  = 3'd1;
  localparam logic [2:0] T_WI  = 3'd2;
  localparam logic [2:0] T_ADD = 3'd3;
  localparam logic [2:0] T_AND = 3'd4;
  localparam logic [2:0] T_OR  = 3'd5;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  logic [p_data_nbits-1:0] mem_q [c_nw];

  logic [c_dn-1:0] req_part;
  logic [c_wn-1:0] req_word;
  logic [c_ln-1:0] req_off;
  logic            req_ok;
  logic            req_fire;
  logic            resp_fire;
  logic            unused_addr_hi;

  logic                      m_full_q, m_full_d;
  logic [2:0]                m_type_q;
  logic [p_opaque_nbits-1:0] m_opaque_q;
  logic [c_ln-1:0]           m_len_q;
  logic [c_dn-1:0]           m_domain_q;
  logic [p_data_nbits-1:0]   m_data_q;
  logic [c_iw-1:0]           m_idx_q;
  logic [c_ln-1:0]           m_off_q;
  logic                      m_err_q;

  logic [p_data_nbits-1:0] cur_w;
  logic [p_data_nbits-1:0] rd_shift;
  logic [p_data_nbits-1:0] rd_mask;
  logic [p_data_nbits-1:0] wr_shift;
  logic [p_data_nbits-1:0] wr_merge;
  logic [p_data_nbits-1:0] wr_word;
  logic [c_ln:0]           off_x, n_x, end_x;
  logic                    is_rd, is_wr, is_amo, rd_all;
  logic                    do_commit;

  state_t          state_q, state_d;
  logic [c_wn-1:0] cnt_q, cnt_d;
  logic [c_dn-1:0] cpart_q, cpart_d;
  logic            clr_we;

  assign req_part = memreq_addr[c_pb +: c_dn];
  assign req_word = memreq_addr[c_pb-1:c_ln];
  assign req_off  = memreq_addr[c_ln-1:0];
  assign req_ok   = (req_part == '0) || (req_part == memreq_domain);
  assign unused_addr_hi = ^memreq_addr[p_addr_nbits-1:c_pb+c_dn];

  assign clear_busy = (state_q == S_CLEAR);
  assign memreq_rdy = !clear_busy && (!m_full_q || memresp_rdy);
  assign req_fire   = memreq_val && memreq_rdy;
  assign resp_fire  = m_full_q && memresp_rdy;
  assign m_full_d   = req_fire || (m_full_q && !memresp_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_full_q <= 1'b0;
    end else begin
      m_full_q <= m_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && req_fire) begin
      m_type_q   <= memreq_type;
      m_opaque_q <= memreq_opaque;
      m_len_q    <= memreq_len;
      m_domain_q <= memreq_domain;
      m_data_q   <= memreq_data;
      m_idx_q    <= {req_part, req_word};
      m_off_q    <= req_off;
      m_err_q    <= !req_ok;
    end
  end

  // Data is read from the array in M so a commit on the accept edge
  // is already visible to the following request.
  assign cur_w  = mem_q[m_idx_q];
  assign is_rd  = (m_type_q == T_RD);
  assign is_wr  = (m_type_q == T_WR) || (m_type_q == T_WI);
  assign is_amo = m_type_q inside {T_ADD, T_AND, T_OR};
  assign rd_all = (m_len_q == '0) || is_amo;

  assign rd_shift = cur_w >> {m_off_q, 3'b000};
  assign wr_shift = m_data_q << {m_off_q, 3'b000};
  assign off_x    = {1'b0, m_off_q};
  assign n_x      = (m_len_q == '0) ? (c_ln+1)'(c_nb) : {1'b0, m_len_q};
  assign end_x    = off_x + n_x;

  always_comb begin
    wr_merge = cur_w;
    rd_mask  = '0;
    for (int b = 0; b < c_nb; b++) begin
      if (((c_ln+1)'(b) >= off_x) && ((c_ln+1)'(b) < end_x)) begin
        wr_merge[b*8 +: 8] = wr_shift[b*8 +: 8];
      end
      if (rd_all || (c_ln'(b) < m_len_q)) begin
        rd_mask[b*8 +: 8] = 8'hff;
      end
    end
  end

  always_comb begin
    wr_word = wr_merge;
    case (m_type_q)
      T_ADD:   wr_word = cur_w + m_data_q;
      T_AND:   wr_word = cur_w & m_data_q;
      T_OR:    wr_word = cur_w | m_data_q;
      default: wr_word = wr_merge;
    endcase
  end

  assign do_commit = resp_fire && !reset && !m_err_q && (is_wr || is_amo);

  assign memresp_val    = m_full_q;
  assign memresp_type   = m_type_q;
  assign memresp_opaque = m_opaque_q;
  assign memresp_len    = m_len_q;
  assign memresp_domain = m_domain_q;
  assign memresp_err    = m_err_q;
  assign memresp_data   = (!m_err_q && (is_rd || is_amo))
                        ? (rd_shift & rd_mask) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpart_d = cpart_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          cpart_d = mem_clear_part;
        end
      end
      S_CLEAR: begin
        if (cnt_q == c_wn'(c_w - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cpart_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpart_q <= cpart_d;
    end
  end

  assign clr_we = clear_busy && !reset;

  // Clear write is issued last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (do_commit) begin
      mem_q[m_idx_q] <= wr_word;
    end
    if (clr_we) begin
      mem_q[{cpart_q, cnt_q}] <= '0;
    end
  end

endmodule

// File: doc/plab5_mcore_test_mem_multi_domain.md
PLAB5_MCORE_TEST_MEM_MULTI_DOMAIN -- requirements
Module: plab5_mcore_test_mem_multi_domain

Interface
REQ-001 SHALL have parameter p_num_parts, default 4: number of equal partitions, power of two, >=2; partition k belongs to security domain k, partition 0 is public.
REQ-002 SHALL have parameter p_part_nbytes, default 256: bytes per partition, power of two, multiple of p_data_nbits/8.
REQ-003 SHALL have parameters p_opaque_nbits (8), p_addr_nbits (32), p_data_nbits (32): message field widths.
REQ-004 SHALL use derived widths: dn = clog2(p_num_parts); ln = clog2(p_data_nbits/8); W = p_part_nbytes/(p_data_nbits/8) words per partition.
REQ-005 SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 memreq_val / memreq_rdy  input / output  1 / 1  request handshake.
REQ-009 memreq_type  input  3  0 read, 1 write, 2 write_init, 3 amo_add, 4 amo_and, 5 amo_or.
REQ-010 memreq_opaque, memreq_addr, memreq_len  input  o, a, ln  tag, byte address, byte count (0 = full word).
REQ-011 memreq_data, memreq_domain  input  d, dn  write/AMO operand; requester security domain.
REQ-012 memresp_val / memresp_rdy  output / input  1 / 1  response handshake.
REQ-013 memresp_type, memresp_opaque, memresp_len  output  3, o, ln  echoed from request.
REQ-014 memresp_data, memresp_domain, memresp_err  output  d, dn, 1  read/old data; echoed domain; access denied.
REQ-015 mem_clear, mem_clear_part  input  1, dn  one-cycle clear command; partition to clear.
REQ-016 clear_busy  output  1  clear FSM active.

Function
REQ-017 Decode: part = addr[clog2(p_part_nbytes) +: dn]; word = addr[clog2(p_part_nbytes)-1 : ln]; offset = addr[ln-1:0]; higher address bits ignored.
REQ-018 Access permitted iff part == 0 or part == memreq_domain; otherwise denied.
REQ-019 Single response stage M (one entry); request accepted when memreq_val && memreq_rdy, captured into M on that edge.
REQ-020 memreq_rdy = !clear_busy && (!M_full || memresp_rdy); enables full throughput of one request per cycle.
REQ-021 memresp_val = M_full; response fields driven from M; response available the cycle after acceptance (latency 1).
REQ-022 Memory update (write, write_init, AMO) commits only on the edge where memresp_val && memresp_rdy; AMO therefore executes exactly once; memresp_data stable while stalled.
REQ-023 Read/AMO data = stored word >> (offset*8), upper bytes beyond len zeroed; AMO returns pre-operation word.
REQ-024 Writes update bytes offset .. offset+len-1 only (len 0 = all d/8 bytes); bytes past word end dropped.
REQ-025 AMO writes whole word: add modulo 2^d, bitwise and, or; len ignored.
REQ-026 Denied access: no memory change, memresp_data = 0, memresp_err = 1; permitted: memresp_err = 0.
REQ-027 memresp_type, opaque, len, domain echo the request unchanged, including denied responses.
REQ-028 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on mem_clear; counter 0..W-1 writes zero to one word of mem_clear_part per cycle; CLEAR->IDLE after word W-1 written.
REQ-029 clear_busy = 1 in CLEAR; mem_clear while busy ignored; an occupied M stage still drains during CLEAR.
REQ-030 M commit and clear write to the same word in one cycle: clear wins.

Reset
REQ-031 Reset SHALL force M_full = 0, FSM to IDLE, counter 0: memresp_val = 0, clear_busy = 0, memreq_rdy = 1 next cycle.
REQ-032 Reset SHALL NOT modify memory contents; reset mid-clear abandons clear, remaining words keep prior values.
REQ-033 Requests and memresp_rdy ignored in reset cycles; an in-flight M entry is discarded without commit.

Verification (p_num_parts 4, p_part_nbytes 256, d 32)
REQ-034 Domain 0 write 0xDEADBEEF to 0x004, then read 0x004 -> response one cycle after accept, data 0xDEADBEEF, err 0.
REQ-035 Domain 1 write 0x12345678 to 0x200 -> err 1, data 0; domain 2 read 0x200 -> previous value unchanged.
REQ-036 Domain 1 amo_add 3 at 0x104 holding 5, memresp_rdy low 3 cycles -> data 5 held stable, one commit, memory 8.
REQ-037 Word 0x11223344 at 0x100; domain 1 write len 1 data 0xAB to 0x101 -> word 0x1122AB44; read len 1 at 0x101 -> 0x000000AB.
REQ-038 mem_clear part 1 -> clear_busy 64 cycles, memreq_rdy 0 throughout; then 0x100..0x1FC read 0, partition 0 unchanged.
REQ-039 Reset asserted at clear cycle 10 -> clear_busy 0, memreq_rdy 1 after reset; words 10..63 of partition retain old values.
